multi_thread_scheduler: RTL and testbench

MULTI_THREAD_SCHEDULER -- requirements
Module: multi_thread_scheduler

---
 rtl/mt_sched_pkg.sv | 24 ++
 rtl/rr_thread_picker.sv | 27 ++
 rtl/multi_thread_scheduler.sv | 159 +++++++++++++++
 tb/tb_multi_thread_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_sched_pkg.sv
// Shared types for the multi-thread scheduler: FSM state encoding and the
// reset-time base PC of each hardware thread.
package mt_sched_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_PICK  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } sched_state_e;

    localparam int unsigned PC_MAX_W = 64;

    // Thread index placed in the top tid_w bits of an addr_w-bit PC, zeros below.
    function automatic logic [PC_MAX_W-1:0] thread_base_pc(
        input int unsigned tid,
        input int unsigned addr_w,
        input int unsigned tid_w
    );
        return PC_MAX_W'(tid) << (addr_w - tid_w);
    endfunction

endpackage

// File: rtl/rr_thread_picker.sv
// Round-robin picker: scans from last+1 (mod NUM_THREADS) and grants the first
// requesting thread; the previous grant is examined last.
module rr_thread_picker #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic [NUM_THREADS-1:0] req,
    input  logic [TID_W-1:0]       last,
    output logic [TID_W-1:0]       grant,
    output logic                   grant_vld
);

    always_comb begin
        int idx;
        grant     = last;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = (int'(last) + i) % NUM_THREADS;
            if (!grant_vld && req[idx]) begin
                grant     = TID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_thread_scheduler.sv
// Coarse-grained multithreading scheduler: switches the running thread on
// completion or long-latency stall, drains the pipe and redirects fetch.
// Optional time-slice preemption is enabled by defining THREAD_SWITCH_TIMEOUT_EN.
module multi_thread_scheduler
    import mt_sched_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int QUANTUM     = 1024,
    localparam int TID_W      = (NUM_THREADS < 2) ? 1 : $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   thread_done,
    input  logic                   stall_switch,
    input  logic [ADDR_WIDTH-1:0]  resume_pc,
    input  logic [NUM_THREADS-1:0] wake,
    input  logic                   pipe_empty,
    output logic [TID_W-1:0]       thread_id,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [NUM_THREADS-1:0] done_vec,
    output logic                   all_done
);

    sched_state_e            state_q, state_d;
    logic [TID_W-1:0]        tid_q, tid_d;
    logic [NUM_THREADS-1:0]  done_q, done_d;
    logic [NUM_THREADS-1:0]  blocked_q, blocked_d;
    logic [ADDR_WIDTH-1:0]   saved_pc_q [NUM_THREADS];
    logic [ADDR_WIDTH-1:0]   saved_pc_d [NUM_THREADS];
    logic                    rv_q, rv_d;
    logic [ADDR_WIDTH-1:0]   rpc_q, rpc_d;

    logic [NUM_THREADS-1:0]  pick_req;
    logic [TID_W-1:0]        pick_grant;
    logic                    pick_vld;

`ifdef THREAD_SWITCH_TIMEOUT_EN
    localparam int CNT_W = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);
    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
    logic             slice_expired;
    assign slice_expired = (slice_cnt_q == CNT_W'(QUANTUM - 1));
`endif

    // A wake arriving this cycle already counts, so WAIT can redirect on the next edge.
    assign pick_req = ~done_q & ~(blocked_q & ~wake);

    rr_thread_picker #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_picker (
        .req       (pick_req),
        .last      (tid_q),
        .grant     (pick_grant),
        .grant_vld (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        done_d     = done_q;
        blocked_d  = blocked_q & ~wake;
        saved_pc_d = saved_pc_q;
        rv_d       = 1'b0;
        rpc_d      = rpc_q;
`ifdef THREAD_SWITCH_TIMEOUT_EN
        slice_cnt_d = slice_cnt_q;
`endif
        case (state_q)
            ST_RUN: begin
`ifdef THREAD_SWITCH_TIMEOUT_EN
                slice_cnt_d = slice_cnt_q + CNT_W'(1);
`endif
                if (thread_done) begin
                    done_d[tid_q] = 1'b1;
                    state_d       = ST_DRAIN;
                end else if (stall_switch) begin
                    // Block is applied after the wake clear so a same-cycle wake loses.
                    saved_pc_d[tid_q] = resume_pc;
                    blocked_d[tid_q]  = 1'b1;
                    state_d           = ST_DRAIN;
                end
`ifdef THREAD_SWITCH_TIMEOUT_EN
                else if (slice_expired) begin
                    saved_pc_d[tid_q] = resume_pc;
                    state_d           = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK, ST_WAIT: begin
                if (&done_q) begin
                    state_d = ST_HALT;
                end else if (pick_vld) begin
                    tid_d   = pick_grant;
                    rv_d    = 1'b1;
                    rpc_d   = saved_pc_q[pick_grant];
                    state_d = ST_RUN;
`ifdef THREAD_SWITCH_TIMEOUT_EN
                    slice_cnt_d = '0;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            tid_q     <= '0;
            done_q    <= '0;
            blocked_q <= '0;
            rv_q      <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                saved_pc_q[i] <= ADDR_WIDTH'(thread_base_pc(i, ADDR_WIDTH, TID_W));
            end
`ifdef THREAD_SWITCH_TIMEOUT_EN
            slice_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            done_q     <= done_d;
            blocked_q  <= blocked_d;
            rv_q       <= rv_d;
            saved_pc_q <= saved_pc_d;
`ifdef THREAD_SWITCH_TIMEOUT_EN
            slice_cnt_q <= slice_cnt_d;
`endif
        end
    end

    // Redirect target is qualified by redirect_valid and needs no reset.
    always_ff @(posedge clk) begin
        rpc_q <= rpc_d;
    end

    assign thread_id      = tid_q;
    assign flush          = (state_q == ST_DRAIN);
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign done_vec       = done_q;
    assign all_done       = &done_q;

endmodule

// File: tb/tb_multi_thread_scheduler.sv
// Directed bench for multi_thread_scheduler: a 4-thread instance for the main
// scenarios and a 2-thread instance for the base-PC switch case.
module tb_multi_thread_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        thread_done, stall_switch, pipe_empty;
    logic [31:0] resume_pc;
    logic [3:0]  wake;
    logic [1:0]  thread_id;
    logic        flush, redirect_valid, all_done;
    logic [31:0] redirect_pc;
    logic [3:0]  done_vec;

    logic        thread_done_b, stall_switch_b, pipe_empty_b;
    logic [31:0] resume_pc_b;
    logic [1:0]  wake_b;
    logic        thread_id_b;
    logic        flush_b, redirect_valid_b, all_done_b;
    logic [31:0] redirect_pc_b;
    logic [1:0]  done_vec_b;

    int n_checks = 0;
    int n_pass   = 0;

    multi_thread_scheduler #(.NUM_THREADS(4), .ADDR_WIDTH(32), .QUANTUM(8)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .thread_done    (thread_done),
        .stall_switch   (stall_switch),
        .resume_pc      (resume_pc),
        .wake           (wake),
        .pipe_empty     (pipe_empty),
        .thread_id      (thread_id),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .done_vec       (done_vec),
        .all_done       (all_done)
    );

    multi_thread_scheduler #(.NUM_THREADS(2), .ADDR_WIDTH(32), .QUANTUM(8)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .thread_done    (thread_done_b),
        .stall_switch   (stall_switch_b),
        .resume_pc      (resume_pc_b),
        .wake           (wake_b),
        .pipe_empty     (pipe_empty_b),
        .thread_id      (thread_id_b),
        .flush          (flush_b),
        .redirect_valid (redirect_valid_b),
        .redirect_pc    (redirect_pc_b),
        .done_vec       (done_vec_b),
        .all_done       (all_done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic s, input logic [31:0] pc, input logic [3:0] w);
        thread_done  = d;
        stall_switch = s;
        resume_pc    = pc;
        wake         = w;
        tick();
        thread_done  = 1'b0;
        stall_switch = 1'b0;
        wake         = '0;
    endtask

    // DRAIN -> PICK on pipe_empty, then PICK resolves on the following edge.
    task automatic drain();
        pipe_empty = 1'b1;
        tick();
        pipe_empty = 1'b0;
        tick();
    endtask

    task automatic expect_switch(input string tag, input logic [1:0] tid, input logic [31:0] pc);
        check({tag, "_rv"},  redirect_valid, 1'b1);
        check({tag, "_tid"}, thread_id, tid);
        check({tag, "_pc"},  redirect_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        thread_done = 0; stall_switch = 0; pipe_empty = 0; resume_pc = '0; wake = '0;
        thread_done_b = 0; stall_switch_b = 0; pipe_empty_b = 0; resume_pc_b = '0; wake_b = '0;
        tick();
        tick();
        check("rst_tid",      thread_id, 2'd0);
        check("rst_flush",    flush, 1'b0);
        check("rst_rv",       redirect_valid, 1'b0);
        check("rst_done",     done_vec, 4'h0);
        check("rst_all_done", all_done, 1'b0);
        check("rst_tid_b",    thread_id_b, 1'b0);
        rst = 1'b0;

        // Two threads: thread 0 completes, thread 1 starts at its base PC.
        thread_done_b = 1'b1;
        tick();
        thread_done_b = 1'b0;
        check("n2_flush", flush_b, 1'b1);
        check("n2_done",  done_vec_b, 2'b01);
        pipe_empty_b = 1'b1;
        tick();
        pipe_empty_b = 1'b0;
        tick();
        check("n2_rv",  redirect_valid_b, 1'b1);
        check("n2_pc",  redirect_pc_b, 32'h8000_0000);
        check("n2_tid", thread_id_b, 1'b1);
        tick();
        check("n2_rv_off", redirect_valid_b, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef THREAD_SWITCH_TIMEOUT_EN
        resume_pc = 32'h800;
        repeat (7) tick();
        check("slice_early", flush, 1'b0);
        tick();
        check("slice_expire", flush, 1'b1);
        resume_pc = '0;
        drain();
        expect_switch("slice_t1", 2'd1, 32'h4000_0000);
        pulse(0, 1, 32'h10, 4'h0);
        drain();
        expect_switch("slice_t2", 2'd2, 32'h8000_0000);
        pulse(0, 1, 32'h20, 4'h0);
        drain();
        expect_switch("slice_t3", 2'd3, 32'hC000_0000);
        pulse(0, 1, 32'h30, 4'h0);
        drain();
        expect_switch("slice_t0_unblocked", 2'd0, 32'h800);
`else
        repeat (12) tick();
        check("no_slice_flush", flush, 1'b0);
        check("no_slice_tid",   thread_id, 2'd0);
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Stall thread 0, drain with a held pipe, switch to thread 1.
        pulse(0, 1, 32'h100, 4'h0);
        check("stall_flush", flush, 1'b1);
        check("stall_done",  done_vec, 4'h0);
        tick();
        check("drain_hold", flush, 1'b1);
        drain();
        expect_switch("sw_t1", 2'd1, 32'h4000_0000);
        tick();
        check("rv_one_cycle", redirect_valid, 1'b0);

        pulse(0, 1, 32'h200, 4'h0);
        drain();
        expect_switch("sw_t2", 2'd2, 32'h8000_0000);
        pulse(0, 1, 32'h300, 4'h0);
        drain();
        expect_switch("sw_t3", 2'd3, 32'hC000_0000);

        // Everyone blocked: WAIT, then wake thread 2.
        pulse(0, 1, 32'h400, 4'h0);
        drain();
        check("wait_rv",    redirect_valid, 1'b0);
        check("wait_flush", flush, 1'b0);
        tick();
        tick();
        check("wait_rv_hold", redirect_valid, 1'b0);
        check("wait_tid",     thread_id, 2'd3);
        pulse(0, 0, 32'h0, 4'b0100);
        expect_switch("wake2", 2'd2, 32'h300);

        // Wake thread 0, then thread 2 finishes with a simultaneous stall.
        pulse(0, 0, 32'h0, 4'b0001);
        pulse(1, 1, 32'h999, 4'h0);
        check("done_over_stall", done_vec, 4'b0100);
        drain();
        expect_switch("resume_t0", 2'd0, 32'h100);

        // Same-cycle wake and block leaves thread 0 blocked.
        pulse(0, 1, 32'h500, 4'b0001);
        drain();
        check("wake_block_same", redirect_valid, 1'b0);
        pulse(0, 0, 32'h0, 4'b1011);
        expect_switch("wake_all", 2'd1, 32'h200);

        pulse(1, 0, 32'h0, 4'h0);
        drain();
        expect_switch("t1_done", 2'd3, 32'h400);
        pulse(1, 0, 32'h0, 4'h0);
        drain();
        expect_switch("t3_done", 2'd0, 32'h500);
        pulse(1, 0, 32'h0, 4'h0);
        drain();
        check("halt_all_done", all_done, 1'b1);
        check("halt_flush",    flush, 1'b0);
        check("halt_done_vec", done_vec, 4'hF);
        check("halt_rv",       redirect_valid, 1'b0);

        thread_done = 1; stall_switch = 1; pipe_empty = 1; wake = 4'hF;
        tick();
        tick();
        thread_done = 0; stall_switch = 0; pipe_empty = 0; wake = '0;
        check("halt_hold_flush", flush, 1'b0);
        check("halt_hold_rv",    redirect_valid, 1'b0);
        check("halt_hold_all",   all_done, 1'b1);
        check("halt_hold_tid",   thread_id, 2'd0);

        // Reset in the middle of a drain abandons the switch.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerst_all_done", all_done, 1'b0);
        pulse(0, 1, 32'h111, 4'h0);
        check("pre_rst_flush", flush, 1'b1);
        rst = 1'b1;
        pipe_empty = 1'b1;
        tick();
        rst = 1'b0;
        pipe_empty = 1'b0;
        check("rst_drain_flush", flush, 1'b0);
        check("rst_drain_rv",    redirect_valid, 1'b0);
        check("rst_drain_tid",   thread_id, 2'd0);
        tick();
        check("rst_drain_nopulse", redirect_valid, 1'b0);
        check("rst_drain_done",    done_vec, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
